// File: rtl/pwl8_exp2_eval.sv
// pwl8_exp2_eval: evaluates 2^x for a signed fixed-point x via an 8-segment
// piecewise-linear coefficient ROM, producing an FP16 result.
// x splits into integer n, segment index (top 3 fraction bits) and offset t;
// the ROM returns (y0, slope) for the segment and the result is
// 2^n * (y0 + slope*t) packed as FP16 with overflow/underflow flags.
// Optional macro PWL8_ROUND_EN: round-to-nearest-even on the mantissa
// instead of truncation.
module pwl8_exp2_eval #(
  parameter int XW = 16,
  parameter int FW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] in_x,
  output logic          rom_valid_o,
  output logic [2:0]    rom_seg_o,
  input  logic          rom_valid_i,
  input  logic [DW-1:0] rom_y0_i,
  input  logic [DW-1:0] rom_slope_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_y,
  output logic          out_ovf,
  output logic          out_udf
);

  localparam int NW = XW - FW;
  localparam int TW = FW - 3;
  localparam int PW = 11 + TW;
  localparam int SW = (PW + 1 > 22) ? PW + 1 : 22;
  localparam int EW = NW + 3;
`ifdef PWL8_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CALC, S_OUT} state_t;

  state_t               state_q, state_d;
  logic                 in_ready_q, rom_valid_q, out_valid_q;
  logic [2:0]           rom_seg_q;
  logic [15:0]          out_y_q;
  logic                 ovf_q, udf_q;
  logic signed [NW-1:0] n_q;
  logic [TW-1:0]        t_q;
  logic [9:0]           y0m_q;
  logic [14:0]          slope_q;

  logic                 accept;
  logic [PW-1:0]        prod;
  int                   sh_amt;
  logic [PW-1:0]        t_term;
  logic [SW-1:0]        s_sum;
  logic                 k;
  logic [9:0]           mant_raw;
  logic [10:0]          disc, half;
  logic                 carry;
  logic [9:0]           mant;
  logic signed [EW-1:0] e_res;
  logic [17:0]          packed_d;

  // The y0 exponent is fixed at 15 and the slope is positive, so these bits carry nothing.
  logic unused_rom;
  assign unused_rom = ^{rom_y0_i[DW-1:10], rom_slope_i[DW-1]};

  // Returns {carry_out, mantissa}; carry_out means the mantissa wrapped past all-ones.
  function automatic logic [10:0] round_mant(input logic [9:0] m, input logic [10:0] d,
                                             input logic [10:0] h);
    logic up;
    up = ROUND_EN && ((d > h) || ((d == h) && m[0]));
    return {(&m) & up, m + {9'd0, up}};
  endfunction

  // Returns {ovf, udf, fp16}; exponent outside 1..30 saturates or flushes.
  function automatic logic [17:0] pack_fp16(input logic signed [EW-1:0] e, input logic [9:0] m);
    if (e >= EW'(31))
      return {2'b10, 16'h7C00};
    else if (e <= EW'(0))
      return {2'b01, 16'h0000};
    else
      return {2'b00, 1'b0, e[4:0], m};
  endfunction

  assign accept      = (state_q == S_IDLE) && in_valid && in_ready_q;
  assign in_ready    = in_ready_q;
  assign rom_valid_o = rom_valid_q;
  assign rom_seg_o   = rom_seg_q;
  assign out_valid   = out_valid_q;
  assign out_y       = out_y_q;
  assign out_ovf     = ovf_q;
  assign out_udf     = udf_q;

  // Next-state logic for the request/evaluate/deliver sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_REQ;
      S_REQ:   state_d = S_WAIT;
      S_WAIT:  if (rom_valid_i) state_d = S_CALC;
      S_CALC:  state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Evaluate y0 + slope*t, normalise, and pack as FP16.
  always_comb begin
    prod   = PW'({1'b1, slope_q[9:0]}) * PW'(t_q);
    sh_amt = 5 + FW - int'(slope_q[14:10]);
    t_term = '0;
    if (sh_amt >= 0 && sh_amt < 32) t_term = prod >> sh_amt;
    s_sum    = SW'({1'b1, y0m_q, 10'd0}) + SW'(t_term);
    k        = |s_sum[SW-1:21];
    mant_raw = k ? s_sum[20:11] : s_sum[19:10];
    disc     = k ? s_sum[10:0] : {1'b0, s_sum[9:0]};
    half     = k ? 11'h400 : 11'h200;
    {carry, mant} = round_mant(mant_raw, disc, half);
    e_res    = EW'(15) + EW'(n_q) + EW'(k) + EW'(carry);
    packed_d = pack_fp16(e_res, mant);
  end

  // Control state and registered outputs; reset clears every output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      rom_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      rom_seg_q   <= '0;
      out_y_q     <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == S_IDLE);
      rom_valid_q <= (state_d == S_REQ);
      out_valid_q <= (state_d == S_OUT);
      if (accept) rom_seg_q <= in_x[FW-1:FW-3];
      if (state_q == S_CALC) begin
        ovf_q   <= packed_d[17];
        udf_q   <= packed_d[16];
        out_y_q <= packed_d[15:0];
      end
    end
  end

  // Operand capture: x fields on accept, ROM words on the WAIT response.
  always_ff @(posedge clk) begin
    if (accept) begin
      n_q <= in_x[XW-1:FW];
      t_q <= in_x[TW-1:0];
    end
    if (state_q == S_WAIT && rom_valid_i) begin
      y0m_q   <= rom_y0_i[9:0];
      slope_q <= rom_slope_i[14:0];
    end
  end

endmodule
